// File: rtl/mips_multicycle_ctrl_pkg.sv
// Shared constants and control-word type for the multicycle MIPS controller.
// Used by both the next-state logic and the output decoder.
package mips_multicycle_ctrl_pkg;

   localparam logic [3:0] S_FETCH    = 4'd0;
   localparam logic [3:0] S_DECODE   = 4'd1;
   localparam logic [3:0] S_MEMADR   = 4'd2;
   localparam logic [3:0] S_MEMRD    = 4'd3;
   localparam logic [3:0] S_MEMWB    = 4'd4;
   localparam logic [3:0] S_MEMWR    = 4'd5;
   localparam logic [3:0] S_EXECUTE  = 4'd6;
   localparam logic [3:0] S_ALUWB    = 4'd7;
   localparam logic [3:0] S_BRANCH   = 4'd8;
   localparam logic [3:0] S_ADDIEXEC = 4'd9;
   localparam logic [3:0] S_ADDIWB   = 4'd10;
   localparam logic [3:0] S_JUMP     = 4'd11;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] ALUB_REGB  = 2'b00;
   localparam logic [1:0] ALUB_FOUR  = 2'b01;
   localparam logic [1:0] ALUB_IMM   = 2'b10;
   localparam logic [1:0] ALUB_IMMSH = 2'b11;

   localparam logic [1:0] PC_ALU    = 2'b00;
   localparam logic [1:0] PC_ALUOUT = 2'b01;
   localparam logic [1:0] PC_JUMP   = 2'b10;

   typedef struct packed {
      logic [1:0] aluop;
      logic       alusrca;
      logic [1:0] alusrcb;
      logic [1:0] pcsrc;
      logic       pcwrite;
      logic       branch;
      logic       iord;
      logic       irwrite;
      logic       memwrite;
      logic       regwrite;
      logic       regdst;
      logic       memtoreg;
   } ctrl_word_t;

   function automatic logic op_supported(input logic [5:0] op);
      case (op)
         OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: op_supported = 1'b1;
         default:                                       op_supported = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_outdec.sv
// State to control-word decoder. Pure combinational; memready qualifies
// the FETCH strobes, branch is resolved against zero in the top.
module ctrl_outdec
   import mips_multicycle_ctrl_pkg::*;
(
   input  logic [3:0]  state_i,
   input  logic        memready_i,
   output ctrl_word_t  cw_o
);

   always_comb begin
      cw_o = '0;
      case (state_i)
         S_FETCH: begin
            cw_o.alusrcb = ALUB_FOUR;
            cw_o.aluop   = ALUOP_ADD;
            cw_o.pcsrc   = PC_ALU;
            cw_o.irwrite = memready_i;
            cw_o.pcwrite = memready_i;
         end
         S_DECODE: begin
            cw_o.alusrcb = ALUB_IMMSH;
            cw_o.aluop   = ALUOP_ADD;
         end
         S_MEMADR, S_ADDIEXEC: begin
            cw_o.alusrca = 1'b1;
            cw_o.alusrcb = ALUB_IMM;
            cw_o.aluop   = ALUOP_ADD;
         end
         S_MEMRD: cw_o.iord = 1'b1;
         S_MEMWR: begin
            cw_o.iord     = 1'b1;
            cw_o.memwrite = 1'b1;
         end
         S_MEMWB: begin
            cw_o.memtoreg = 1'b1;
            cw_o.regwrite = 1'b1;
         end
         S_EXECUTE: begin
            cw_o.alusrca = 1'b1;
            cw_o.alusrcb = ALUB_REGB;
            cw_o.aluop   = ALUOP_FUNCT;
         end
         S_ALUWB: begin
            cw_o.regdst   = 1'b1;
            cw_o.regwrite = 1'b1;
         end
         S_BRANCH: begin
            cw_o.alusrca = 1'b1;
            cw_o.alusrcb = ALUB_REGB;
            cw_o.aluop   = ALUOP_SUB;
            cw_o.pcsrc   = PC_ALUOUT;
            cw_o.branch  = 1'b1;
         end
         S_ADDIWB: cw_o.regwrite = 1'b1;
         S_JUMP: begin
            cw_o.pcsrc   = PC_JUMP;
            cw_o.pcwrite = 1'b1;
         end
         default: cw_o = '0;
      endcase
   end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS main controller: one state register, next-state logic here,
// control word from ctrl_outdec. Write strobes are forced low while in reset.
module mips_multicycle_ctrl
   import mips_multicycle_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       reset_n,
   input  logic [5:0] op,
   input  logic       zero,
   input  logic       memready,
   output logic [1:0] aluop,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic [1:0] pcsrc,
   output logic       pcen,
   output logic       iord,
   output logic       irwrite,
   output logic       memwrite,
   output logic       regwrite,
   output logic       regdst,
   output logic       memtoreg,
   output logic       illegal_op,
   output logic [3:0] state_dbg
);

   // state      | meaning
   // FETCH      | read instruction at PC, PC += 4 when memory ready
   // DECODE     | register read, branch target precompute, dispatch on op
   // MEMADR     | effective address for lw/sw
   // MEMRD      | data read, waits for memready
   // MEMWB      | load data written to rt
   // MEMWR      | data write, waits for memready
   // EXECUTE    | R-type ALU operation
   // ALUWB      | ALU result written to rd
   // BRANCH     | beq compare, PC <= target if zero
   // ADDIEXEC   | rs + sign-extended immediate
   // ADDIWB     | addi result written to rt
   // JUMP       | PC <= jump target
   // 12..15     | unreachable, recover to FETCH

   logic [3:0]  state_q, state_d;
   ctrl_word_t  cw;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= S_FETCH;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = S_FETCH;
      case (state_q)
         S_FETCH:    state_d = memready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (op)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_RTYPE:     state_d = S_EXECUTE;
               OP_BEQ:       state_d = S_BRANCH;
               OP_ADDI:      state_d = S_ADDIEXEC;
               OP_J:         state_d = S_JUMP;
               default:      state_d = S_FETCH;
            endcase
         end
         S_MEMADR:   state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
         S_MEMRD:    state_d = memready ? S_MEMWB : S_MEMRD;
         S_MEMWR:    state_d = memready ? S_FETCH : S_MEMWR;
         S_EXECUTE:  state_d = S_ALUWB;
         S_ADDIEXEC: state_d = S_ADDIWB;
         default:    state_d = S_FETCH;
      endcase
   end

   ctrl_outdec u_outdec (
      .state_i    (state_q),
      .memready_i (memready),
      .cw_o       (cw)
   );

   assign aluop      = cw.aluop;
   assign alusrca    = cw.alusrca;
   assign alusrcb    = cw.alusrcb;
   assign pcsrc      = cw.pcsrc;
   assign iord       = cw.iord;
   assign regdst     = cw.regdst;
   assign memtoreg   = cw.memtoreg;
   assign pcen       = reset_n & (cw.pcwrite | (cw.branch & zero));
   assign irwrite    = reset_n & cw.irwrite;
   assign memwrite   = reset_n & cw.memwrite;
   assign regwrite   = reset_n & cw.regwrite;
   assign illegal_op = reset_n & (state_q == S_DECODE) & ~op_supported(op);
   assign state_dbg  = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: directed instruction runs plus random
// instruction streams, checked against an instruction-level path model.
module tb_mips_multicycle_ctrl;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [5:0] op;
   logic       zero;
   logic       memready;
   logic [1:0] aluop;
   logic       alusrca;
   logic [1:0] alusrcb;
   logic [1:0] pcsrc;
   logic       pcen, iord, irwrite, memwrite, regwrite, regdst, memtoreg, illegal_op;
   logic [3:0] state_dbg;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mips_multicycle_ctrl dut (
      .clk(clk), .reset_n(reset_n), .op(op), .zero(zero), .memready(memready),
      .aluop(aluop), .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc),
      .pcen(pcen), .iord(iord), .irwrite(irwrite), .memwrite(memwrite),
      .regwrite(regwrite), .regdst(regdst), .memtoreg(memtoreg),
      .illegal_op(illegal_op), .state_dbg(state_dbg)
   );

   wire [14:0] obs = {aluop, alusrca, alusrcb, pcsrc, pcen, iord, irwrite,
                      memwrite, regwrite, regdst, memtoreg, illegal_op};
   wire [4:0]  strobes = {pcen, irwrite, memwrite, regwrite, illegal_op};

   task automatic check(input string tag, input logic [15:0] o, input logic [15:0] e);
      checks++;
      assert (o === e) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, o, e);
      end
   endtask

   function automatic bit legal(input logic [5:0] o);
      return o inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010};
   endfunction

   // Expected outputs straight from the per-state output table.
   function automatic logic [14:0] exp_out(input int s, input bit mr, input bit z,
                                           input logic [5:0] o);
      logic [1:0] ao, bsel, ps;
      logic       a, pe, io, ir, mw, rw, rd, mt, il;
      {ao, a, bsel, ps, pe, io, ir, mw, rw, rd, mt, il} = '0;
      case (s)
         0:  begin bsel = 2'b01; ir = mr; pe = mr; end
         1:  begin bsel = 2'b11; il = !legal(o); end
         2:  begin a = 1; bsel = 2'b10; end
         3:  io = 1;
         4:  begin mt = 1; rw = 1; end
         5:  begin io = 1; mw = 1; end
         6:  begin a = 1; ao = 2'b10; end
         7:  begin rd = 1; rw = 1; end
         8:  begin a = 1; ao = 2'b01; ps = 2'b01; pe = z; end
         9:  begin a = 1; bsel = 2'b10; end
         10: rw = 1;
         11: begin ps = 2'b10; pe = 1; end
         default: ;
      endcase
      return {ao, a, bsel, ps, pe, io, ir, mw, rw, rd, mt, il};
   endfunction

   // Runs one instruction from FETCH; returns cycles spent.
   task automatic run_instr(input logic [5:0] iop, input bit rnd, input int fetch_stalls,
                            input bit zf, output int cycles);
      int path[$];
      int idx, stalls;
      bit mr, z;
      path = {0, 1};
      case (iop)
         6'b100011: path = {path, 2, 3, 4};
         6'b101011: path = {path, 2, 5};
         6'b000000: path = {path, 6, 7};
         6'b000100: path = {path, 8};
         6'b001000: path = {path, 9, 10};
         6'b000010: path = {path, 11};
         default: ;
      endcase
      cycles = 0; idx = 0; stalls = 0;
      while (idx < path.size()) begin
         @(negedge clk);
         if (rnd) begin
            mr = ($urandom_range(0, 3) != 0) || (stalls >= 8);
            z  = 1'($urandom_range(0, 1));
         end else begin
            mr = !(path[idx] == 0 && stalls < fetch_stalls);
            z  = zf;
         end
         op = iop; memready = mr; zero = z;
         #1;
         check($sformatf("state op=%b step%0d", iop, idx), {12'd0, state_dbg}, 16'(path[idx]));
         check($sformatf("outs op=%b s%0d mr=%0d z=%0d", iop, path[idx], mr, z),
               {1'b0, obs}, {1'b0, exp_out(path[idx], mr, z, iop)});
         cycles++;
         if ((path[idx] inside {0, 3, 5}) && !mr) stalls++;
         else begin idx++; stalls = 0; end
      end
   endtask

   int cyc;
   logic [5:0] rop;
   logic [5:0] ops [6] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010};

   initial begin
      reset_n = 1'b0; op = '0; zero = 1'b0; memready = 1'b1;
      #2;
      check("reset state", {12'd0, state_dbg}, 16'd0);
      check("reset strobes", {11'd0, strobes}, 16'd0);
      @(negedge clk); memready = 1'b0; reset_n = 1'b1;

      run_instr(6'b100011, 0, 0, 0, cyc); check("lat lw", 16'(cyc), 16'd5);
      run_instr(6'b000000, 0, 3, 0, cyc); check("lat R fetch stall 3", 16'(cyc), 16'd7);
      run_instr(6'b000100, 0, 0, 1, cyc); check("lat beq z1", 16'(cyc), 16'd3);
      run_instr(6'b000100, 0, 0, 0, cyc); check("lat beq z0", 16'(cyc), 16'd3);
      run_instr(6'b111111, 0, 0, 0, cyc); check("lat illegal", 16'(cyc), 16'd2);
      run_instr(6'b001000, 0, 0, 0, cyc); check("lat addi", 16'(cyc), 16'd4);
      run_instr(6'b000010, 0, 0, 0, cyc); check("lat j", 16'(cyc), 16'd3);
      run_instr(6'b101011, 0, 0, 0, cyc); check("lat sw", 16'(cyc), 16'd4);
      run_instr(6'b000000, 0, 0, 0, cyc); check("lat R", 16'(cyc), 16'd4);

      // sw stalled in MEMWR, then reset mid-cycle
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         op = 6'b101011; memready = (k < 3); zero = 1'b0;
         #1;
         check($sformatf("sw rst walk %0d", k), {12'd0, state_dbg}, (k == 3) ? 16'd5 : 16'(k));
      end
      check("memwrite before reset", {15'd0, memwrite}, 16'd1);
      #2 reset_n = 1'b0; memready = 1'b1;
      #1;
      check("memwrite at reset", {15'd0, memwrite}, 16'd0);
      check("state at reset", {12'd0, state_dbg}, 16'd0);
      check("strobes at reset", {11'd0, strobes}, 16'd0);
      @(posedge clk); #1;
      check("strobes held in reset", {11'd0, strobes}, 16'd0);
      check("state held in reset", {12'd0, state_dbg}, 16'd0);
      @(negedge clk); memready = 1'b0; reset_n = 1'b1;

      for (int n = 0; n < 60; n++) begin
         if ($urandom_range(0, 7) == 0) rop = 6'($urandom_range(0, 63));
         else rop = ops[$urandom_range(0, 5)];
         run_instr(rop, 1, 0, 0, cyc);
      end

      @(negedge clk); memready = 1'b0; #1;
      check("final state", {12'd0, state_dbg}, 16'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
